morse_tx: RTL
=============

# morse_tx

Morse transmitter for the translator datapath, the output-side counterpart of the button debouncer. The debouncer turns timed human key presses into clean events; this block turns a character code into a correctly timed on/off keying waveform. Its `key_out` drives the LED or buzzer. It accepts one character per start/ready handshake from the encoder/control FSM.

## Interface
- `UNIT_CYCLES`, default 5000000: clk cycles per Morse time unit (50 ms at 100 MHz); legal range 2..2^24.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: request transmit; accepted only when `ready`=1.
- `sym_len` input 3: element count 1..5; 0 means word gap; 6 and 7 are treated as 5.
- `sym_bits` input 5: element code, bit i = element i, sent LSB first; 1 is dash, 0 is dot; bits ≥ `sym_len` are ignored.
- `key_out` output 1: keying output, 1 means tone/LED on.
- `ready` output 1: idle, can accept `start`.
- `busy` output 1: equals ~`ready`.
- `done` output 1: one-cycle pulse when a character or gap finishes.

## Operation
- FSM states:
  - IDLE
  - MARK: `key_out`=1
  - SPACE: intra-character gap, `key_out`=0
  - CHAR_GAP: trailing gap, `key_out`=0
  - WORD_GAP: `key_out`=0
- IDLE transitions on `start`&`ready`:
  - Latch `sym_bits` and the clamped length into shift/count registers; later input changes have no effect.
  - `sym_len`=0 goes to WORD_GAP. Otherwise go to MARK for element 0.
- Each state loads a unit count:
  - MARK: 1 (dot) or 3 (dash)
  - SPACE: 1
  - CHAR_GAP: 3
  - WORD_GAP: 7
- The state decrements its unit count on each `unit_tick` and exits when the count reaches 0.
- State exits:
  - MARK goes to SPACE if elements remain, else to CHAR_GAP.
  - SPACE goes to MARK with the next element, shifting `sym_bits` right.
  - CHAR_GAP and WORD_GAP go to IDLE and pulse `done`.
- `start` while `busy` is ignored: no queuing, no error.
- Reset values:
  - `key_out`=0, `ready`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Reset mid-operation drops `key_out` to 0 asynchronously and discards the character.

## Timing
- U = `UNIT_CYCLES`. All outputs are registered.
- Start accepted at edge 0:
  - `key_out` and `busy` change at edge 0.
  - The unit prescaler clears at edge 0, so the first unit is exactly U cycles.
- Every MARK/SPACE/GAP interval is exactly (units × U) cycles. There is no ±1 slop at segment boundaries.
- Character duration T = Σmarks + (len−1)·U + 3U. Word gap T = 7U.
- At edge T: `done`=1 for one cycle, `ready`=1, `key_out`=0.
- Earliest next accepted `start` is sampled at edge T+1. A back-to-back stream therefore adds exactly 1 idle cycle per character.
- Prescaler width is ceil(log2(U)) bits; it counts 0..U−1 and ticks at U−1.
- Unit counter is 3 bits (max 7); element counter is 3 bits. No wrap is reachable.

## Structure
- `morse_pkg` (shared with the receive-side decoder) holds:
  - state encoding
  - `DOT_UNITS`=1, `DASH_UNITS`=3, `ELEM_GAP_UNITS`=1, `CHAR_GAP_UNITS`=3, `WORD_GAP_UNITS`=7, `MAX_ELEMS`=5
- Sub-module `morse_unit_timer`:
  - Parameter U.
  - Inputs `clk`, `rst`, `clear`; output `unit_tick`, a one-cycle pulse every U cycles after `clear`.
  - The FSM asserts `clear` on `start` acceptance.

## Test plan
All scenarios use U=4.
- 'E' (`sym_len`=1, `sym_bits`=00000) → `key_out` high 4 cycles, low 12; `done` at edge 16; `ready` low edges 0..15.
- 'T' (1, 00001) → high 12, low 12; `done` at edge 24.
- 'A' (2, 00010) → high 4, low 4, high 12, low 12; `done` at edge 32. 'N' (2, 00001) gives high 12, low 4, high 4, low 12.
- Word gap (`sym_len`=0) → `key_out` stays 0; `busy` for 28 cycles; `done` at edge 28.
- '0' with `sym_len`=7, `sym_bits`=11111 → five 12-cycle marks, 4-cycle gaps, 12-cycle trailer; `done` at 88. A `start` pulsed at edge 20 is ignored.
- Reset asserted during the second mark of 'A' → `key_out`=0 and `ready`=1 immediately. After release, 'E' transmits with exact 4/12 timing.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse timing constants and state encoding for the transmit and receive datapaths.
package morse_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StMark    = 3'd1;
  localparam logic [2:0] StSpace   = 3'd2;
  localparam logic [2:0] StCharGap = 3'd3;
  localparam logic [2:0] StWordGap = 3'd4;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;
  localparam logic [2:0] MAX_ELEMS      = 3'd5;

  // Lengths 6 and 7 behave as 5; 0 stays 0 (word gap).
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > MAX_ELEMS) ? MAX_ELEMS : len;
  endfunction

  function automatic logic [2:0] mark_units(input logic is_dash);
    return is_dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running prescaler producing one unit_tick every U cycles, re-phased by clear.
module morse_unit_timer #(
  parameter int unsigned U = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic unit_tick_o
);

  localparam int unsigned CntW = (U > 1) ? $clog2(U) : 1;
  localparam logic [CntW-1:0] Last = CntW'(U - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clear_i || (cnt_q == Last)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign unit_tick_o = (cnt_q == Last);

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: turns one latched character code into a unit-timed keying waveform.
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [2:0] sym_len_i,
  input  logic [4:0] sym_bits_i,
  output logic       key_out_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o
);

  logic [2:0] state_q, state_d;
  logic [2:0] units_q, units_d;
  logic [2:0] elems_q, elems_d;
  logic [4:0] bits_q, bits_d;
  logic       key_q, ready_q, done_q, done_d;
  logic       clear;
  logic       unit_tick;
  logic [2:0] len_clamped;
  logic [4:0] bits_shifted;

  assign len_clamped  = clamp_len(sym_len_i);
  assign bits_shifted = bits_q >> 1;

  morse_unit_timer #(
    .U(UNIT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .unit_tick_o(unit_tick)
  );

  always_comb begin
    state_d = state_q;
    units_d = units_q;
    elems_d = elems_q;
    bits_d  = bits_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    if (state_q == StIdle) begin
      if (start_i && ready_q) begin
        clear  = 1'b1;
        bits_d = sym_bits_i;
        if (len_clamped == 3'd0) begin
          state_d = StWordGap;
          units_d = WORD_GAP_UNITS;
          elems_d = 3'd0;
        end else begin
          state_d = StMark;
          units_d = mark_units(sym_bits_i[0]);
          elems_d = len_clamped - 3'd1;
        end
      end
    end else if (unit_tick) begin
      if (units_q != 3'd1) begin
        units_d = units_q - 3'd1;
      end else begin
        // Last unit of this segment: pick the next segment and load its length.
        case (state_q)
          StMark: begin
            if (elems_q != 3'd0) begin
              state_d = StSpace;
              units_d = ELEM_GAP_UNITS;
            end else begin
              state_d = StCharGap;
              units_d = CHAR_GAP_UNITS;
            end
          end
          StSpace: begin
            state_d = StMark;
            bits_d  = bits_shifted;
            elems_d = elems_q - 3'd1;
            units_d = mark_units(bits_shifted[0]);
          end
          StCharGap, StWordGap: begin
            state_d = StIdle;
            units_d = 3'd0;
            done_d  = 1'b1;
          end
          default: begin
            state_d = StIdle;
            units_d = 3'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      units_q <= 3'd0;
      elems_q <= 3'd0;
      bits_q  <= 5'd0;
      key_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      elems_q <= elems_d;
      bits_q  <= bits_d;
      key_q   <= (state_d == StMark);
      ready_q <= (state_d == StIdle);
      done_q  <= done_d;
    end
  end

  assign key_out_o = key_q;
  assign ready_o   = ready_q;
  assign busy_o    = ~ready_q;
  assign done_o    = done_q;

endmodule
